// File: rtl/ctrl_pkg.sv
// Shared encodings and control bundles for the pipelined MIPS main-control unit.
package ctrl_pkg;

    localparam int CTRL_ALU_OP_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLE   = 6'b000111;
    localparam logic [5:0] OP_BLT   = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [CTRL_ALU_OP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_RTYPE = 3'b010;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_LUI   = 3'b011;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OR    = 3'b100;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BLE = 2'b01,
        BR_BLT = 2'b10,
        BR_BNE = 2'b11
    } branch_type_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_PC4 = 2'b11
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'b00,
        DST_RT   = 2'b01,
        DST_RD   = 2'b10,
        DST_LINK = 2'b11
    } reg_dst_e;

    typedef struct packed {
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic                     alu_src;
        reg_dst_e                 reg_dst;
    } ex_ctrl_t;

    typedef struct packed {
        logic         mem_read;
        logic         mem_write;
        logic         branch;
        branch_type_e branch_type;
        logic         jump;
        logic         jump_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        mem_to_reg_e mem_to_reg;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        logic r;
        case (op)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE, OP_BLE, OP_BLT: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_pipe_decoder_if.sv
// IF/ID-side inputs and per-stage control outputs of the pipelined control unit.
interface ctrl_pipe_decoder_if #(
    parameter int ALU_OP_W   = 3,
    parameter int REG_ADDR_W = 5
);
    logic [31:0]           instr_i;
    logic                  instr_valid_i;
    logic                  flush_i;
    logic [ALU_OP_W-1:0]   ex_alu_op_o;
    logic                  ex_alu_src_o;
    logic [5:0]            ex_funct_o;
    logic [REG_ADDR_W-1:0] ex_wr_reg_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic                  mem_branch_o;
    logic [1:0]            mem_branch_type_o;
    logic                  mem_jump_o;
    logic                  mem_jump_reg_o;
    logic                  wb_reg_write_o;
    logic [1:0]            wb_mem_to_reg_o;
    logic [REG_ADDR_W-1:0] wb_wr_reg_o;
    logic                  hazard_stall_o;
    logic                  illegal_o;

    modport master (
        output instr_i, instr_valid_i, flush_i,
        input  ex_alu_op_o, ex_alu_src_o, ex_funct_o, ex_wr_reg_o,
        input  mem_read_o, mem_write_o, mem_branch_o, mem_branch_type_o, mem_jump_o, mem_jump_reg_o,
        input  wb_reg_write_o, wb_mem_to_reg_o, wb_wr_reg_o, hazard_stall_o, illegal_o
    );

    modport slave (
        input  instr_i, instr_valid_i, flush_i,
        output ex_alu_op_o, ex_alu_src_o, ex_funct_o, ex_wr_reg_o,
        output mem_read_o, mem_write_o, mem_branch_o, mem_branch_type_o, mem_jump_o, mem_jump_reg_o,
        output wb_reg_write_o, wb_mem_to_reg_o, wb_wr_reg_o, hazard_stall_o, illegal_o
    );
endinterface

// File: rtl/ctrl_main_dec.sv
// Combinational opcode/funct decode into EX/MEM/WB control bundles plus illegal flag.
module ctrl_main_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ex_ctrl_t   ex_ctrl,
    output mem_ctrl_t  mem_ctrl,
    output wb_ctrl_t   wb_ctrl,
    output logic       illegal
);

    // Main decode table; unknown opcodes leave a bubble and raise illegal.
    always_comb begin
        ex_ctrl  = EX_BUBBLE;
        mem_ctrl = MEM_BUBBLE;
        wb_ctrl  = WB_BUBBLE;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FUNCT_JR) begin
                    mem_ctrl.jump_reg = 1'b1;
                end else begin
                    ex_ctrl.alu_op    = ALU_RTYPE;
                    ex_ctrl.reg_dst   = DST_RD;
                    wb_ctrl.reg_write = 1'b1;
                end
            end
            OP_LW: begin
                ex_ctrl.alu_src    = 1'b1;
                ex_ctrl.reg_dst    = DST_RT;
                mem_ctrl.mem_read  = 1'b1;
                wb_ctrl.reg_write  = 1'b1;
                wb_ctrl.mem_to_reg = M2R_MEM;
            end
            OP_SW: begin
                ex_ctrl.alu_src    = 1'b1;
                mem_ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLE, OP_BLT: begin
                ex_ctrl.alu_op  = ALU_SUB;
                mem_ctrl.branch = 1'b1;
                case (opcode)
                    OP_BNE:  mem_ctrl.branch_type = BR_BNE;
                    OP_BLE:  mem_ctrl.branch_type = BR_BLE;
                    OP_BLT:  mem_ctrl.branch_type = BR_BLT;
                    default: mem_ctrl.branch_type = BR_BEQ;
                endcase
            end
            OP_ADDI, OP_ORI, OP_LUI: begin
                case (opcode)
                    OP_ORI:  ex_ctrl.alu_op = ALU_OR;
                    OP_LUI:  ex_ctrl.alu_op = ALU_LUI;
                    default: ex_ctrl.alu_op = ALU_ADD;
                endcase
                ex_ctrl.alu_src   = 1'b1;
                ex_ctrl.reg_dst   = DST_RT;
                wb_ctrl.reg_write = 1'b1;
            end
            OP_J: begin
                mem_ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                mem_ctrl.jump      = 1'b1;
                ex_ctrl.reg_dst    = DST_LINK;
                wb_ctrl.reg_write  = 1'b1;
                wb_ctrl.mem_to_reg = M2R_PC4;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Pipelined main control: decode in ID, carry bundles through ID/EX, EX/MEM, MEM/WB.
// Load-use stall detection is built only when CTRL_HAZARD_EN is defined.
module ctrl_pipe_decoder
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W   = 3,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ctrl_pipe_decoder_if.slave bus
);

    logic [5:0]            id_op_s;
    logic [REG_ADDR_W-1:0] id_rt_s;
    logic [REG_ADDR_W-1:0] id_rd_s;
    logic [REG_ADDR_W-1:0] id_wr_reg_s;
    ex_ctrl_t              dec_ex_s;
    mem_ctrl_t             dec_mem_s;
    wb_ctrl_t              dec_wb_s;
    wb_ctrl_t              id_wb_s;
    logic                  dec_illegal_s;
    logic                  stall_s;
    logic                  id_kill_s;
    logic                  unused_s;

    ex_ctrl_t              ex_ctrl_r;
    mem_ctrl_t             ex_mem_r;
    wb_ctrl_t              ex_wb_r;
    logic [5:0]            ex_funct_r;
    logic [REG_ADDR_W-1:0] ex_wr_reg_r;
    logic                  illegal_r;
    mem_ctrl_t             mem_ctrl_r;
    wb_ctrl_t              mem_wb_r;
    logic [REG_ADDR_W-1:0] mem_wr_reg_r;
    wb_ctrl_t              wb_ctrl_r;
    logic [REG_ADDR_W-1:0] wb_wr_reg_r;

    assign id_op_s = bus.instr_i[31:26];
    assign id_rt_s = REG_ADDR_W'(bus.instr_i[20:16]);
    assign id_rd_s = REG_ADDR_W'(bus.instr_i[15:11]);

    ctrl_main_dec u_main_dec (
        .opcode   (id_op_s),
        .funct    (bus.instr_i[5:0]),
        .ex_ctrl  (dec_ex_s),
        .mem_ctrl (dec_mem_s),
        .wb_ctrl  (dec_wb_s),
        .illegal  (dec_illegal_s)
    );

    // RegDst resolution; a $0 destination never produces a write.
    always_comb begin
        case (dec_ex_s.reg_dst)
            DST_RT:   id_wr_reg_s = id_rt_s;
            DST_RD:   id_wr_reg_s = id_rd_s;
            DST_LINK: id_wr_reg_s = REG_ADDR_W'(LINK_REG);
            default:  id_wr_reg_s = '0;
        endcase
        id_wb_s = dec_wb_s;
        if (id_wr_reg_s == '0) begin
            id_wb_s.reg_write = 1'b0;
        end else begin
            id_wb_s.reg_write = dec_wb_s.reg_write;
        end
    end

`ifdef CTRL_HAZARD_EN
    logic [REG_ADDR_W-1:0] id_rs_s;
    logic                  hit_s;

    assign id_rs_s  = REG_ADDR_W'(bus.instr_i[25:21]);
    assign unused_s = ^{bus.instr_i[10:6], ex_ctrl_r.reg_dst};

    // Load-use detection against the load sitting in EX; a flush overrides it.
    always_comb begin
        if ((ex_wr_reg_r == id_rs_s) || (reads_rt(id_op_s) && (ex_wr_reg_r == id_rt_s))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (!bus.flush_i && bus.instr_valid_i && ex_mem_r.mem_read && (ex_wr_reg_r != '0) && hit_s) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end
`else
    assign stall_s  = 1'b0;
    assign unused_s = ^{bus.instr_i[25:21], bus.instr_i[10:6], ex_ctrl_r.reg_dst};
`endif

    assign id_kill_s = !bus.instr_valid_i || dec_illegal_s || stall_s || bus.flush_i;

    // ID/EX register and the registered illegal pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i || id_kill_s) begin
            ex_ctrl_r   <= EX_BUBBLE;
            ex_mem_r    <= MEM_BUBBLE;
            ex_wb_r     <= WB_BUBBLE;
            ex_funct_r  <= 6'd0;
            ex_wr_reg_r <= '0;
        end else begin
            ex_ctrl_r   <= dec_ex_s;
            ex_mem_r    <= dec_mem_s;
            ex_wb_r     <= id_wb_s;
            ex_funct_r  <= bus.instr_i[5:0];
            ex_wr_reg_r <= id_wr_reg_s;
        end
        if (rst_i) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= bus.instr_valid_i && dec_illegal_s && !stall_s && !bus.flush_i;
        end
    end

    // EX/MEM register; a flush kills the branch/jump slot resolving in EX.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            mem_ctrl_r   <= MEM_BUBBLE;
            mem_wb_r     <= WB_BUBBLE;
            mem_wr_reg_r <= '0;
        end else begin
            mem_ctrl_r   <= ex_mem_r;
            mem_wb_r     <= ex_wb_r;
            mem_wr_reg_r <= ex_wr_reg_r;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ctrl_r   <= WB_BUBBLE;
            wb_wr_reg_r <= '0;
        end else begin
            wb_ctrl_r   <= mem_wb_r;
            wb_wr_reg_r <= mem_wr_reg_r;
        end
    end

    assign bus.ex_alu_op_o       = ALU_OP_W'(ex_ctrl_r.alu_op);
    assign bus.ex_alu_src_o      = ex_ctrl_r.alu_src;
    assign bus.ex_funct_o        = ex_funct_r;
    assign bus.ex_wr_reg_o       = ex_wr_reg_r;
    assign bus.mem_read_o        = mem_ctrl_r.mem_read;
    assign bus.mem_write_o       = mem_ctrl_r.mem_write;
    assign bus.mem_branch_o      = mem_ctrl_r.branch;
    assign bus.mem_branch_type_o = mem_ctrl_r.branch_type;
    assign bus.mem_jump_o        = mem_ctrl_r.jump;
    assign bus.mem_jump_reg_o    = mem_ctrl_r.jump_reg;
    assign bus.wb_reg_write_o    = wb_ctrl_r.reg_write;
    assign bus.wb_mem_to_reg_o   = wb_ctrl_r.mem_to_reg;
    assign bus.wb_wr_reg_o       = wb_wr_reg_r;
    assign bus.hazard_stall_o    = stall_s;
    assign bus.illegal_o         = illegal_r;

endmodule
